aud_rec_writer: RTL

Record-side counterpart of the playback DSP. It accepts parallel 16-bit ADC samples from the I2S deserializer and applies a latched power-of-two gain with saturation. Each sample is written into the external SRAM at an auto-incrementing address, one write per sample. It publishes the last written address, which the playback DSP takes as its playback end address.

---
 rtl/aud_pkg.sv | 29 ++
 rtl/aud_gain_sat.sv | 36 +++
 rtl/aud_rec_writer.sv | 129 ++++++++++++
 3 files changed

// File: rtl/aud_pkg.sv
`default_nettype none
// ============================================================================
// Module      : aud_pkg
// Description : Shared types and constants for the audio record/playback
//               path: recorder state encoding, sample saturation limits and
//               default SRAM address / sample widths.
// Revision    : 1.0 - initial release
// ============================================================================
package aud_pkg;

    // Defaults shared by the recorder and the playback DSP
    localparam int AUD_ADDR_W = 20;
    localparam int AUD_DATA_W = 16;

    // Saturation limits of a signed 16-bit sample
    localparam logic signed [15:0] SAMPLE_MAX = 16'sh7FFF;
    localparam logic signed [15:0] SAMPLE_MIN = 16'sh8000;

    // Recorder control states
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ARM    = 3'd1,
        ST_WRITE  = 3'd2,
        ST_PAUSED = 3'd3,
        ST_DONE   = 3'd4
    } rec_state_t;

endpackage
`default_nettype wire

// File: rtl/aud_gain_sat.sv
`default_nettype none
// ============================================================================
// Module      : aud_gain_sat
// Description : Combinational power-of-two gain (left shift 0..3) on a signed
//               16-bit sample, saturated back into the 16-bit signed range.
// Revision    : 1.0 - initial release
// ============================================================================
module aud_gain_sat
    import aud_pkg::*;
(
    input  logic [15:0] sample,
    input  logic [1:0]  gain,
    output logic [15:0] result
);

    // Three guard bits hold the largest shift (x8) without overflow
    localparam logic signed [18:0] SAT_HI = 19'sh07FFF;
    localparam logic signed [18:0] SAT_LO = 19'sh78000;

    logic signed [18:0] extended;
    logic signed [18:0] shifted;

    // Sign-extend, shift, then clamp anything outside the 16-bit range
    always_comb begin
        extended = {{3{sample[15]}}, sample};
        shifted  = extended <<< gain;
        result   = shifted[15:0];
        if (shifted > SAT_HI) begin
            result = SAMPLE_MAX;
        end else if (shifted < SAT_LO) begin
            result = SAMPLE_MIN;
        end
    end

endmodule
`default_nettype wire

// File: rtl/aud_rec_writer.sv
`default_nettype none
// ============================================================================
// Module      : aud_rec_writer
// Description : Record-side SRAM writer. Takes deserialized ADC samples,
//               applies a latched power-of-two gain with saturation and
//               writes each sample to an auto-incrementing SRAM address.
//               Publishes the last written address as the playback end.
// Revision    : 1.0 - initial release
// ============================================================================
module aud_rec_writer
    import aud_pkg::*;
#(
    parameter int                ADDR_W   = AUD_ADDR_W,
    parameter int                DATA_W   = AUD_DATA_W,
    parameter logic [ADDR_W-1:0] MAX_ADDR = {ADDR_W{1'b1}}
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_start,
    input  logic              i_pause,
    input  logic              i_stop,
    input  logic [1:0]        i_gain,
    input  logic [DATA_W-1:0] i_adc_data,
    input  logic              i_adc_valid,
    output logic [ADDR_W-1:0] o_sram_addr,
    output logic [DATA_W-1:0] o_sram_data,
    output logic              o_sram_we_n,
    output logic [ADDR_W-1:0] o_rec_end,
    output logic              o_finish,
    output logic              o_recorder_en,
    output logic              o_drop
);

    rec_state_t        state;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] sram_data;
    logic              we_n;
    logic [ADDR_W-1:0] rec_end;
    logic              drop;
    logic [1:0]        gain;
    logic [DATA_W-1:0] processed;

    // Gain is applied with the value latched at start/resume, not the live pin
    aud_gain_sat u_gain_sat (
        .sample (i_adc_data),
        .gain   (gain),
        .result (processed)
    );

    // Recorder FSM: commands resolved stop > pause > start; one write per sample
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state     <= ST_IDLE;
            addr      <= '0;
            sram_data <= '0;
            we_n      <= 1'b1;
            rec_end   <= '0;
            drop      <= 1'b0;
            gain      <= 2'd0;
        end else begin
            // Write strobe lasts exactly the single WRITE cycle
            we_n <= 1'b1;

            // The write in flight always completes, even under stop or pause
            if (state == ST_WRITE) begin
                rec_end <= addr;
                if (i_adc_valid) begin
                    drop <= 1'b1;
                end
            end

            if (i_stop) begin
                state <= ST_IDLE;
                addr  <= '0;
            end else begin
                case (state)
                    ST_IDLE, ST_DONE: begin
                        if (i_start) begin
                            state   <= ST_ARM;
                            addr    <= '0;
                            rec_end <= '0;
                            drop    <= 1'b0;
                            gain    <= i_gain;
                        end
                    end
                    ST_PAUSED: begin
                        // Resume keeps the address; gain may be changed
                        if (i_start) begin
                            state <= ST_ARM;
                            gain  <= i_gain;
                        end
                    end
                    ST_ARM: begin
                        if (i_pause) begin
                            state <= ST_PAUSED;
                        end else if (i_adc_valid) begin
                            sram_data <= processed;
                            we_n      <= 1'b0;
                            state     <= ST_WRITE;
                        end
                    end
                    ST_WRITE: begin
                        // The last writable address ends the recording in place
                        if (addr == MAX_ADDR) begin
                            state <= ST_DONE;
                        end else begin
                            addr  <= addr + ADDR_W'(1);
                            state <= i_pause ? ST_PAUSED : ST_ARM;
                        end
                    end
                    default: begin
                        state <= ST_IDLE;
                        addr  <= '0;
                    end
                endcase
            end
        end
    end

    assign o_sram_addr   = addr;
    assign o_sram_data   = sram_data;
    assign o_sram_we_n   = we_n;
    assign o_rec_end     = rec_end;
    assign o_drop        = drop;
    assign o_finish      = (state == ST_DONE);
    assign o_recorder_en = (state == ST_ARM) || (state == ST_WRITE);

endmodule
`default_nettype wire
